mprj_io_pad_seq: RTL and testbench



---
 rtl/mprj_io_pad_seq_pkg.sv | 25 ++
 rtl/mprj_io_pad_seq_if.sv | 27 ++
 rtl/mprj_io_in_filt.sv | 83 ++++++++
 rtl/mprj_io_pad_seq.sv | 137 +++++++++++++
 tb/tb_mprj_io_pad_seq.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mprj_io_pad_seq_pkg.sv
// Shared definitions for the user-project pad sequencer: config-word layout,
// reset word, sequencer state encoding and a small address-width helper.
package mprj_io_pad_seq_pkg;

    localparam int CFG_W           = 5;
    localparam int CFG_OEB_BIT     = 0;
    localparam int CFG_INP_DIS_BIT = 1;
    localparam int CFG_DM_LSB      = 2;
    localparam int CFG_DM_W        = 3;

    typedef logic [CFG_W-1:0] cfg_word_t;

    // dm=3'b001, inp_dis=1, oeb=1: pad safely tri-stated with input disabled
    localparam cfg_word_t CFG_RESET = 5'b00111;

    typedef logic [1:0] seq_state_t;
    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_APPLY = 2'd1;
    localparam seq_state_t ST_DONE  = 2'd2;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mprj_io_pad_seq_if.sv
// Shadow-config write and apply handshake between a host and the pad sequencer.
interface mprj_io_pad_seq_if #(
    parameter int NUM_PADS = 38
) ();
    import mprj_io_pad_seq_pkg::*;

    localparam int AW = addr_w(NUM_PADS);

    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    cfg_word_t     cfg_wdata;
    logic          cfg_err;
    logic          apply_req;
    logic          apply_busy;
    logic          apply_done;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, apply_req,
        input  cfg_err, apply_busy, apply_done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, apply_req,
        output cfg_err, apply_busy, apply_done
    );

endinterface

// File: rtl/mprj_io_in_filt.sv
// One pad input: multi-stage synchronizer, optional glitch filter and sticky
// rising-edge flag with write-1-to-clear (a coincident set wins).
module mprj_io_in_filt #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic io_in,
    input  logic edge_en,
    input  logic edge_clr,
    output logic io_in_filt,
    output logic edge_pend
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   synced;
    logic                   prev_q, prev_d;
    logic                   pend_q, pend_d;
    logic                   rise;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], io_in};
    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (FILT_LEN == 0) begin : g_bypass
            assign io_in_filt = synced;
        end else begin : g_filt
            localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

            logic [3:0] cnt_q, cnt_d;
            logic       filt_q, filt_d;

            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            always_comb begin
                cnt_d  = cnt_q;
                filt_d = filt_q;
                if (synced == filt_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    filt_d = synced;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign io_in_filt = filt_q;
        end
    endgenerate

    always_comb begin
        rise   = io_in_filt & ~prev_q;
        prev_d = io_in_filt;
        pend_d = (pend_q & ~edge_clr) | (rise & edge_en);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign edge_pend = pend_q;

endmodule

// File: rtl/mprj_io_pad_seq.sv
// User-project pad sequencer: shadow pad configuration copied into the live
// pad controls one pad every STEP_CYC cycles, plus filtered pad inputs and edge IRQ.
module mprj_io_pad_seq
    import mprj_io_pad_seq_pkg::*;
#(
    parameter int NUM_PADS    = 38,
    parameter int STEP_CYC    = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    mprj_io_pad_seq_if.slave      cfg_if,
    output logic [NUM_PADS-1:0]   pad_oeb,
    output logic [NUM_PADS-1:0]   pad_inp_dis,
    output logic [3*NUM_PADS-1:0] pad_dm,
    input  logic [NUM_PADS-1:0]   io_in,
    output logic [NUM_PADS-1:0]   io_in_filt,
    input  logic [NUM_PADS-1:0]   edge_en,
    input  logic [NUM_PADS-1:0]   edge_clr,
    output logic [NUM_PADS-1:0]   edge_pend,
    output logic                  irq
);

    localparam int              AW        = addr_w(NUM_PADS);
    localparam logic [AW:0]     PAD_CNT   = (AW+1)'(NUM_PADS);
    localparam logic [AW-1:0]   IDX_LAST  = AW'(NUM_PADS - 1);
    localparam logic [7:0]      STEP_LAST = 8'(STEP_CYC - 1);

    cfg_word_t  shadow_q [NUM_PADS];
    cfg_word_t  shadow_d [NUM_PADS];
    cfg_word_t  live_q   [NUM_PADS];
    cfg_word_t  live_d   [NUM_PADS];
    seq_state_t state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    step_q, step_d;
    logic          cfg_err_q, cfg_err_d;
    logic          irq_q, irq_d;
    logic          addr_ok;

    assign addr_ok = ({1'b0, cfg_if.cfg_addr} < PAD_CNT);

    always_comb begin
        shadow_d  = shadow_q;
        cfg_err_d = 1'b0;
        if (cfg_if.cfg_we) begin
            if (addr_ok) begin
                shadow_d[cfg_if.cfg_addr] = cfg_if.cfg_wdata;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // Sequencer reads shadow_q, so a write landing on the same edge as its pad's
    // load is picked up only by the next apply.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = step_q;
        live_d  = live_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_if.apply_req) begin
                    state_d = ST_APPLY;
                    idx_d   = '0;
                    step_d  = '0;
                end
            end
            ST_APPLY: begin
                if (step_q == STEP_LAST) begin
                    live_d[idx_q] = shadow_q[idx_q];
                    step_d        = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end else begin
                    step_d = step_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign irq_d = |edge_pend;

    // NOTE: the config arrays are reset explicitly because the pads must come up in a known safe mode.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            step_q    <= '0;
            cfg_err_q <= 1'b0;
            irq_q     <= 1'b0;
            for (int i = 0; i < NUM_PADS; i++) begin
                shadow_q[i] <= CFG_RESET;
                live_q[i]   <= CFG_RESET;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            step_q    <= step_d;
            cfg_err_q <= cfg_err_d;
            irq_q     <= irq_d;
            shadow_q  <= shadow_d;
            live_q    <= live_d;
        end
    end

    assign cfg_if.cfg_err    = cfg_err_q;
    assign cfg_if.apply_busy = (state_q != ST_IDLE);
    assign cfg_if.apply_done = (state_q == ST_DONE);
    assign irq               = irq_q;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        assign pad_oeb[i]            = live_q[i][CFG_OEB_BIT];
        assign pad_inp_dis[i]        = live_q[i][CFG_INP_DIS_BIT];
        assign pad_dm[3*i +: 3]      = live_q[i][CFG_DM_LSB +: CFG_DM_W];

        mprj_io_in_filt #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_in_filt (
            .wb_clk_i   (wb_clk_i),
            .wb_rst_i   (wb_rst_i),
            .io_in      (io_in[i]),
            .edge_en    (edge_en[i]),
            .edge_clr   (edge_clr[i]),
            .io_in_filt (io_in_filt[i]),
            .edge_pend  (edge_pend[i])
        );
    end

endmodule

// File: tb/tb_mprj_io_pad_seq.sv
// Self-checking bench for mprj_io_pad_seq: scoreboarded apply sequences,
// shadow-write error handling, input filter/edge capture and mid-apply reset.
module tb_mprj_io_pad_seq;
    import mprj_io_pad_seq_pkg::*;

    localparam int NP = 38;
    localparam int AW = addr_w(NP);

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   pad_oeb, pad_inp_dis, io_in, io_in_filt, edge_en, edge_clr, edge_pend;
    logic [3*NP-1:0] pad_dm;
    logic            irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int        pad;
        cfg_word_t word;
    } exp_t;

    exp_t      exp_q[$];
    cfg_word_t shadow_m [NP];
    cfg_word_t live_m   [NP];

    always #5 clk = ~clk;

    mprj_io_pad_seq_if #(.NUM_PADS(NP)) bus ();

    mprj_io_pad_seq #(
        .NUM_PADS(NP), .STEP_CYC(1), .SYNC_STAGES(2), .FILT_LEN(4)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cfg_if      (bus),
        .pad_oeb     (pad_oeb),
        .pad_inp_dis (pad_inp_dis),
        .pad_dm      (pad_dm),
        .io_in       (io_in),
        .io_in_filt  (io_in_filt),
        .edge_en     (edge_en),
        .edge_clr    (edge_clr),
        .edge_pend   (edge_pend),
        .irq         (irq)
    );

    function automatic cfg_word_t live_word(input int i);
        return {pad_dm[3*i +: 3], pad_inp_dis[i], pad_oeb[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.apply_req = 1'b0;
        io_in         = '0;
        edge_en       = '0;
        edge_clr      = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NP; i++) begin
            shadow_m[i] = CFG_RESET;
            live_m[i]   = CFG_RESET;
        end
        exp_q.delete();
    endtask

    task automatic cfg_write(input int addr, input cfg_word_t data);
        logic want_err;
        want_err      = (addr >= NP);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = AW'(addr);
        bus.cfg_wdata = data;
        tick();
        total++;
        if (bus.cfg_err !== want_err) begin
            bad++;
            $display("FAIL cfg_err_pulse addr=%0d: got %0b want %0b", addr, bus.cfg_err, want_err);
        end
        bus.cfg_we = 1'b0;
        if (addr < NP) shadow_m[addr] = data;
        tick();
        total++;
        if (bus.cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err_one_cycle addr=%0d: got %0b want 0", addr, bus.cfg_err);
        end
    endtask

    // apply_req held for reassert_cycles extra cycles; mid_write rewrites pads 20 and 1 during APPLY
    task automatic run_apply(input int reassert_cycles, input bit mid_write);
        exp_t e;
        int   done_cnt;
        done_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < NP; i++) exp_q.push_back('{pad: i, word: shadow_m[i]});
        bus.apply_req = 1'b1;
        tick();
        total++;
        if (bus.apply_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_start: got %0b want 1", bus.apply_busy);
        end
        for (int k = 1; k <= NP; k++) begin
            if (k > reassert_cycles) bus.apply_req = 1'b0;
            if (mid_write && k == 3) begin
                bus.cfg_we = 1'b1; bus.cfg_addr = AW'(20); bus.cfg_wdata = 5'b01010;
                shadow_m[20] = 5'b01010;
                foreach (exp_q[j]) if (exp_q[j].pad == 20) exp_q[j].word = 5'b01010;
            end else if (mid_write && k == 4) begin
                bus.cfg_we = 1'b1; bus.cfg_addr = AW'(1); bus.cfg_wdata = 5'b10110;
                shadow_m[1] = 5'b10110;
                foreach (exp_q[j]) if (exp_q[j].pad == 1) exp_q[j].word = 5'b10110;
            end else begin
                bus.cfg_we = 1'b0;
            end
            tick();
            if (bus.apply_done === 1'b1) done_cnt++;
            e = exp_q.pop_front();
            total++;
            if (live_word(e.pad) !== e.word) begin
                bad++;
                $display("FAIL live_update pad=%0d cyc=%0d: got %b want %b", e.pad, k, live_word(e.pad), e.word);
            end
            if (e.pad + 1 < NP) begin
                total++;
                if (live_word(e.pad + 1) !== live_m[e.pad + 1]) begin
                    bad++;
                    $display("FAIL live_early pad=%0d cyc=%0d: got %b want %b", e.pad + 1, k, live_word(e.pad + 1), live_m[e.pad + 1]);
                end
            end
            live_m[e.pad] = e.word;
        end
        total++;
        if (bus.apply_done !== 1'b1 || bus.apply_busy !== 1'b1) begin
            bad++;
            $display("FAIL done_cycle: got done=%0b busy=%0b want 1 1", bus.apply_done, bus.apply_busy);
        end
        bus.cfg_we    = 1'b0;
        bus.apply_req = 1'b0;
        tick();
        total++;
        if (bus.apply_busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_end: got %0b want 0", bus.apply_busy);
        end
        for (int t = 0; t < 4; t++) begin
            if (bus.apply_done === 1'b1) done_cnt++;
            tick();
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL done_count: got %0d want 1", done_cnt);
        end
        for (int i = 0; i < NP; i++) begin
            total++;
            if (live_word(i) !== live_m[i]) begin
                bad++;
                $display("FAIL live_final pad=%0d: got %b want %b", i, live_word(i), live_m[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < NP; i++) begin
            total++;
            if (live_word(i) !== CFG_RESET) begin
                bad++;
                $display("FAIL reset_live pad=%0d: got %b want %b", i, live_word(i), CFG_RESET);
            end
        end
        total++;
        if ({bus.apply_busy, bus.apply_done, bus.cfg_err, irq} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_status: got %b want 0000", {bus.apply_busy, bus.apply_done, bus.cfg_err, irq});
        end
        total++;
        if (edge_pend !== '0 || io_in_filt !== '0) begin
            bad++;
            $display("FAIL reset_inputs: got pend=%h filt=%h want 0 0", edge_pend, io_in_filt);
        end
    endtask

    task automatic test_apply_basic();
        cfg_write(5, 5'b11000);
        run_apply(0, 1'b0);
        total++;
        if (pad_dm[17:15] !== 3'b110 || pad_oeb[5] !== 1'b0) begin
            bad++;
            $display("FAIL pad5_fields: got dm=%b oeb=%b want 110 0", pad_dm[17:15], pad_oeb[5]);
        end
    endtask

    task automatic test_cfg_err();
        cfg_write(NP, 5'b10101);
        cfg_write((1 << AW) - 1, 5'b01100);
        cfg_write(7, 5'b01101);
        run_apply(0, 1'b0);
    endtask

    task automatic test_mid_write();
        run_apply(0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NP; i++) cfg_write(i, ~shadow_m[i]);
        run_apply(10, 1'b0);
    endtask

    task automatic test_filter();
        logic seen;
        logic got;
        int   lat;
        edge_en    = '0;
        edge_en[0] = 1'b1;
        io_in      = '0;
        io_in[0]   = 1'b1;
        io_in[1]   = 1'b1;
        seen       = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (t == 3) io_in = '0;
            seen = seen | io_in_filt[0] | edge_pend[0];
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL short_pulse: got filt/pend=1 want 0");
        end
        io_in[0] = 1'b1;
        io_in[1] = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 6) io_in = '0;
            if (io_in_filt[0] === 1'b1) begin
                got = 1'b1;
                lat = t;
                break;
            end
        end
        total++;
        if (!got || lat != 6) begin
            bad++;
            $display("FAIL filt_rise: got seen=%0b lat=%0d want 1 6", got, lat);
        end
        total++;
        if (edge_pend[0] !== 1'b0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL pend_early: got pend=%0b irq=%0b want 0 0", edge_pend[0], irq);
        end
        tick();
        total++;
        if (edge_pend[1:0] !== 2'b01 || irq !== 1'b0) begin
            bad++;
            $display("FAIL pend_set: got pend=%b irq=%0b want 01 0", edge_pend[1:0], irq);
        end
        tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set: got %0b want 1", irq);
        end
    endtask

    task automatic test_edge_clr();
        logic got;
        got = 1'b0;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (io_in_filt[0] === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if (!got || edge_pend[0] !== 1'b1) begin
            bad++;
            $display("FAIL filt_fall_sticky: got fell=%0b pend=%0b want 1 1", got, edge_pend[0]);
        end
        io_in[0] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (io_in_filt[0] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL filt_rise2: got 0 want 1");
        end
        edge_clr[0] = 1'b1;
        tick();
        total++;
        if (edge_pend[0] !== 1'b1) begin
            bad++;
            $display("FAIL set_wins: got %0b want 1", edge_pend[0]);
        end
        tick();
        total++;
        if (edge_pend[0] !== 1'b0) begin
            bad++;
            $display("FAIL clr: got %0b want 0", edge_pend[0]);
        end
        edge_clr[0] = 1'b0;
        tick();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clr: got %0b want 0", irq);
        end
        io_in = '0;
    endtask

    task automatic test_reset_mid_apply();
        int done_cnt;
        int drift;
        for (int i = 9; i < NP; i++) cfg_write(i, 5'b10000 | 5'(i & 3));
        bus.apply_req = 1'b1;
        tick();
        bus.apply_req = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        total++;
        if (live_word(9) !== shadow_m[9] || live_word(10) !== live_m[10]) begin
            bad++;
            $display("FAIL pre_abort: got p9=%b p10=%b want %b %b", live_word(9), live_word(10), shadow_m[9], live_m[10]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done_cnt = 0;
        drift    = 0;
        for (int t = 0; t < 50; t++) begin
            if (bus.apply_done === 1'b1) done_cnt++;
            for (int i = 10; i < NP; i++) if (live_word(i) !== CFG_RESET) drift++;
            tick();
        end
        total++;
        if (done_cnt != 0 || bus.apply_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_done: got done_cnt=%0d busy=%0b want 0 0", done_cnt, bus.apply_busy);
        end
        total++;
        if (drift != 0) begin
            bad++;
            $display("FAIL abort_live: got %0d non-reset pad samples want 0", drift);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_apply_basic();
        test_cfg_err();
        test_mid_write();
        test_back_to_back();
        test_filter();
        test_edge_clr();
        test_reset_mid_apply();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
